scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Sequential address generator that sits directly upstream of the 3-to-8 decoder and drives its `a`/`b`/`c` select inputs. It steps through a programmable subset of the 8 decoder lines and holds each selected line for a programmable number of cycles. It runs either continuously or as a single pass. Downstream logic gates the decoder outputs with `valid`.

## Interface

- `DWELL_W`, default 8: width of the dwell-count input and internal dwell counter.

Ports:

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `stop`  in  1  abort the scan; honoured in any state.
- `one_shot`  in  1  1 = single pass then stop; 0 = continuous wrap. Sampled on accepted start.
- `mask`  in  8  bit i = 1 means line i is visited. Sampled on accepted start.
- `dwell`  in  DWELL_W  each line is held for `dwell`+1 cycles. Sampled on accepted start.
- `a`  out  1  select MSB (index bit 2).
- `b`  out  1  select bit 1.
- `c`  out  1  select LSB (index bit 0).
- `valid`  out  1  the select is meaningful; decoder output may be used.
- `busy`  out  1  FSM is in SCAN.
- `step`  out  1  one-cycle pulse on the first cycle of each newly presented index, including the first index.
- `done`  out  1  one-cycle pulse when a one-shot pass completes, or when start is given with mask == 0.

## Operation

- States: IDLE, SCAN.
- Reset: state IDLE. `a`/`b`/`c`/`valid`/`busy`/`step`/`done` = 0. Latched mask/dwell/one_shot = 0. Dwell counter = 0.
- IDLE:
  - `{a,b,c}` = 000, `valid` = 0.
  - `start`=1 and `stop`=0 with mask ≠ 0: latch inputs, load index = lowest set bit of mask, load dwell counter = `dwell`, go to SCAN.
  - `start`=1 and `stop`=0 with mask == 0: remain in IDLE and pulse `done`.
- SCAN:
  - `valid` = `busy` = 1.
  - The dwell counter decrements each cycle.
  - When the counter reaches 0, the next index is the next set mask bit strictly after the current one, circularly. The counter reloads with the latched dwell.
  - Wrap: the next index is ≤ the current index. A single-bit mask always wraps to itself.
  - On wrap with `one_shot`=1: go to IDLE and pulse `done`. No further index is presented.
  - On wrap with `one_shot`=0: continue at the lowest set bit.
- `stop` in SCAN: go to IDLE on the next edge. No `done` pulse. Stop overrides a concurrent wrap or step.
- `start` in SCAN is ignored. Changes to `mask`/`dwell`/`one_shot` during SCAN have no effect.
- `start` and `stop` together in IDLE: stop wins and no scan begins.
- `dwell` = 0: a new index every cycle, and `step` stays high continuously.

## Timing

- All outputs are registered.
- Start accepted at edge N: from cycle N+1, `busy`=`valid`=1, `{a,b,c}` = first index, `step`=1.
- Each index is presented for exactly `dwell`+1 cycles. `step` is high on the first of those cycles.
- One-shot pass over k enabled lines: busy for k·(`dwell`+1) cycles. On the following cycle, `busy`=`valid`=0, `{a,b,c}`=000, `done`=1.
- Stop asserted in cycle M: from cycle M+1, `busy`=`valid`=0 and `{a,b,c}`=000.
- `rst` has priority over every input and takes effect mid-scan with no `done`.
- Back-to-back: start is accepted in the cycle after `done` (state is already IDLE).

## Structure

- Package `scan_pkg`:
  - state enum `scan_state_t` {IDLE, SCAN}
  - `NUM_LINES` = 8
  - `IDX_W` = 3
- Sub-module `mask_next_idx`, combinational:
  - inputs: mask[7:0], cur[2:0]
  - outputs: nxt[2:0], wrap
  - The first index is obtained as `mask_next_idx(mask, 3'd7)`.
- The top level holds the FSM, the dwell counter and the output registers.

## Test plan

- Reset mid-scan (mask=8'hFF, dwell=3, `rst` pulsed at cycle 6) -> all outputs 0 on the next cycle; no `done`.
- One-shot: mask=8'b1010_0100, dwell=1, one_shot=1 -> indices 2,2,5,5,7,7 with `step` on the 1st/3rd/5th cycles; then `done`=1, `valid`=0, abc=000.
- Continuous: mask=8'h81, dwell=0 -> abc alternates 000,111,000,111…; `step` held high; `done` never asserted.
- Stop mid-dwell: mask=8'hFF, dwell=4, stop at the 3rd cycle of index 1 -> next cycle `busy`=0, abc=000, `done`=0; a start in the same cycle as stop is ignored.
- Mask=0 with start -> `done` pulse one cycle later, `busy` stays 0. Single-bit mask 8'h10 with one_shot=1, dwell=2 -> index 4 for 3 cycles, then `done`.
- Inputs changed mid-scan (mask switched to 8'h01 during SCAN, start re-asserted) -> original sequence unaffected.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and sizes for the decoder scan sequencer.
package scan_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scan_sequencer_mask_next_idx.sv
// Finds the next enabled line strictly after cur, searching circularly.
// wrap flags that the search came back to cur or went past line 7.
module mask_next_idx
  import scan_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask,
  input  logic [IDX_W-1:0]     cur,
  output logic [IDX_W-1:0]     nxt,
  output logic                 wrap
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Priority search; offset NUM_LINES lands back on cur so a single-bit mask maps to itself
  always_comb begin
    nxt     = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_LINES; i++) begin
      cand_s = cur + i[IDX_W-1:0];
      if (!found_s && mask[cand_s]) begin
        nxt     = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps the 3-to-8 decoder select through the enabled lines, holding each
// for dwell+1 cycles, in continuous or single-pass mode.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 one_shot,
  input  logic [NUM_LINES-1:0] mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 valid,
  output logic                 busy,
  output logic                 step,
  output logic                 done
);

  scan_state_t          state_r;
  logic [NUM_LINES-1:0] mask_r;
  logic [DWELL_W-1:0]   dwell_r;
  logic                 one_shot_r;
  logic [IDX_W-1:0]     idx_r;
  logic [DWELL_W-1:0]   cnt_r;

  logic [IDX_W-1:0]     first_idx_s;
  logic                 first_wrap_s;
  logic [IDX_W-1:0]     next_idx_s;
  logic                 next_wrap_s;

  // Searching from line 7 yields the lowest set bit of the live mask
  mask_next_idx u_first (
    .mask (mask),
    .cur  (3'd7),
    .nxt  (first_idx_s),
    .wrap (first_wrap_s)
  );

  mask_next_idx u_next (
    .mask (mask_r),
    .cur  (idx_r),
    .nxt  (next_idx_s),
    .wrap (next_wrap_s)
  );

  // Scan FSM with dwell counter and registered decoder-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mask_r     <= {NUM_LINES{1'b0}};
      dwell_r    <= {DWELL_W{1'b0}};
      one_shot_r <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      cnt_r      <= {DWELL_W{1'b0}};
      {a, b, c}  <= 3'b000;
      valid      <= 1'b0;
      busy       <= 1'b0;
      step       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          step <= 1'b0;
          if (start && !stop && (mask != {NUM_LINES{1'b0}})) begin
            mask_r     <= mask;
            dwell_r    <= dwell;
            one_shot_r <= one_shot;
            idx_r      <= first_idx_s;
            cnt_r      <= dwell;
            {a, b, c}  <= first_idx_s;
            valid      <= 1'b1;
            busy       <= 1'b1;
            step       <= 1'b1;
            done       <= 1'b0;
            state_r    <= SCAN;
          end else begin
            {a, b, c}  <= 3'b000;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= start && !stop;
          end
        end
        SCAN: begin
          if (stop) begin
            state_r   <= IDLE;
            {a, b, c} <= 3'b000;
            valid     <= 1'b0;
            busy      <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
          end else if (cnt_r == {DWELL_W{1'b0}}) begin
            if (next_wrap_s && one_shot_r) begin
              state_r   <= IDLE;
              {a, b, c} <= 3'b000;
              valid     <= 1'b0;
              busy      <= 1'b0;
              step      <= 1'b0;
              done      <= 1'b1;
            end else begin
              // On wrap the circular search already returns the lowest set bit
              idx_r     <= next_idx_s;
              {a, b, c} <= next_idx_s;
              cnt_r     <= dwell_r;
              step      <= 1'b1;
              done      <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
            step  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          {a, b, c} <= 3'b000;
          valid     <= 1'b0;
          busy      <= 1'b0;
          step      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: inputs change and outputs are checked on
// the falling edge, against hand-computed per-cycle output vectors.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic       a, b, c, valid, busy, step, done;

  int n_cmp = 0;
  int n_err = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .mask(mask), .dwell(dwell), .a(a), .b(b), .c(c), .valid(valid),
    .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {busy, valid, step, done, a, b, c}
  function automatic logic [6:0] ev(input logic bz, input logic st, input logic dn,
                                    input logic [2:0] ix);
    return {bz, bz, st, dn, ix};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {busy, valid, step, done, a, b, c};
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic go(input logic [7:0] m, input logic [7:0] d, input logic os);
    mask = m; dwell = d; one_shot = os; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] seq_idx [6];
    logic       seq_stp [6];
    seq_idx = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
    seq_stp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    tick(); tick();
    chk("reset", ev(1'b0, 1'b0, 1'b0, 3'd0));
    rst = 1'b0;
    tick();
    chk("idle_after_reset", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // Reset mid-scan: mask FF, dwell 3, rst during cycle 6
    go(8'hFF, 8'd3, 1'b0);
    chk("rst_scan_c1", ev(1'b1, 1'b1, 1'b0, 3'd0));
    tick(); tick(); tick(); tick();
    chk("rst_scan_c5", ev(1'b1, 1'b1, 1'b0, 3'd1));
    tick();
    chk("rst_scan_c6", ev(1'b1, 1'b0, 1'b0, 3'd1));
    rst = 1'b1;
    tick();
    chk("rst_mid_scan", ev(1'b0, 1'b0, 1'b0, 3'd0));
    rst = 1'b0;
    tick();
    chk("rst_no_done", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // One-shot pass over lines 2,5,7 with dwell 1
    go(8'b1010_0100, 8'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("oneshot_c%0d", i + 1), ev(1'b1, seq_stp[i], 1'b0, seq_idx[i]));
      tick();
    end
    chk("oneshot_done", ev(1'b0, 1'b0, 1'b1, 3'd0));
    // Back-to-back start in the done cycle: single-bit mask, dwell 2
    go(8'h10, 8'd2, 1'b1);
    chk("single_c1", ev(1'b1, 1'b1, 1'b0, 3'd4));
    tick();
    chk("single_c2", ev(1'b1, 1'b0, 1'b0, 3'd4));
    tick();
    chk("single_c3", ev(1'b1, 1'b0, 1'b0, 3'd4));
    tick();
    chk("single_done", ev(1'b0, 1'b0, 1'b1, 3'd0));
    tick();
    chk("single_done_clear", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // Continuous, mask 81, dwell 0: alternating 0/7 with step held
    go(8'h81, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_c%0d", i + 1), ev(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? 3'd0 : 3'd7));
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // Stop at the 3rd cycle of index 1 (mask FF, dwell 4), with start alongside
    go(8'hFF, 8'd4, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    chk("stop_idx1_c1", ev(1'b1, 1'b1, 1'b0, 3'd1));
    tick(); tick();
    chk("stop_idx1_c3", ev(1'b1, 1'b0, 1'b0, 3'd1));
    stop = 1'b1; start = 1'b1;
    tick();
    chk("stop_mid_dwell", ev(1'b0, 1'b0, 1'b0, 3'd0));
    tick();
    chk("stop_beats_start_idle", ev(1'b0, 1'b0, 1'b0, 3'd0));
    stop = 1'b0; start = 1'b0;
    tick();
    chk("stop_settled", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // Empty mask: done pulse only
    go(8'h00, 8'd3, 1'b0);
    chk("mask0_done", ev(1'b0, 1'b0, 1'b1, 3'd0));
    tick();
    chk("mask0_clear", ev(1'b0, 1'b0, 1'b0, 3'd0));

    // Inputs changed mid-scan have no effect on the latched sequence
    go(8'b0000_0110, 8'd0, 1'b1);
    chk("latch_c1", ev(1'b1, 1'b1, 1'b0, 3'd1));
    mask = 8'h01; dwell = 8'd5; one_shot = 1'b0; start = 1'b1;
    tick();
    chk("latch_c2", ev(1'b1, 1'b1, 1'b0, 3'd2));
    start = 1'b0;
    tick();
    chk("latch_done", ev(1'b0, 1'b0, 1'b1, 3'd0));
    tick();
    chk("latch_idle", ev(1'b0, 1'b0, 1'b0, 3'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
